// File: rtl/kgp_pkg.sv
// Shared KGPminiRISC control definitions: datapath width, PC step and the
// fetch/execute state encoding used by the sequencer and the control unit.
package kgp_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/execute bus between the PC sequencer, instruction memory, decode
// and the branch unit. master = sequencer side, slave = surrounding core.
interface pc_sequencer_if;

  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] instr_in;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic        halted;
  logic        misalign_err;

  modport master (
    input  start, imem_ack, instr_in, exec_done, branch_taken, branch_target, halt,
    output imem_req, imem_addr, instr_out, instr_valid, pc_out, pc_plus4, halted,
           misalign_err
  );

  modport slave (
    output start, imem_ack, instr_in, exec_done, branch_taken, branch_target, halt,
    input  imem_req, imem_addr, instr_out, instr_valid, pc_out, pc_plus4, halted,
           misalign_err
  );

endinterface

// File: rtl/pc_increment.sv
// PC incrementer shared by the sequencer: produces pc + STEP, wrapping
// modulo 2^WIDTH.
module pc_increment #(
  parameter int          WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  assign pc_next = pc + STEP_W;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for KGPminiRISC: fetches over a req/ack handshake,
// hands each instruction to decode and selects the next PC after execute.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | out of reset, waiting for start
//   ST_FETCH | imem_req high at imem_addr=PC until imem_ack
//   ST_EXEC  | instruction with datapath, waiting for exec_done
//   ST_HALT  | stopped by halt request; only reset exits
//   ST_ERROR | stopped by misaligned branch target; only reset exits
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pc_sequencer_if.master        bus
);

  import kgp_pkg::*;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc_next_seq;
  logic [XLEN-1:0]   instr_q;
  logic              instr_valid_q;
  logic              misalign_q, misalign_d;
  logic              load_instr;

  pc_increment #(
    .WIDTH (XLEN),
    .STEP  (PC_STEP)
  ) PC_increment (
    .pc      (pc_q),
    .pc_next (pc_next_seq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= load_instr;
      misalign_q    <= misalign_d;
      if (load_instr) begin
        instr_q <= bus.instr_in;
      end
    end
  end

  // halt outranks branch, and a misaligned redirect stops the core with PC held
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    load_instr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          load_instr = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.exec_done) begin
          if (bus.halt) begin
            state_d = ST_HALT;
          end else if (bus.branch_taken) begin
            if (bus.branch_target[1:0] != 2'b00) begin
              misalign_d = 1'b1;
              state_d    = ST_ERROR;
            end else begin
              pc_d    = bus.branch_target;
              state_d = ST_FETCH;
            end
          end else begin
            pc_d    = pc_next_seq;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // request and halted decode straight from state so reset clears them at once
  assign bus.imem_req     = (state_q == ST_FETCH);
  assign bus.imem_addr    = pc_q;
  assign bus.pc_out       = pc_q;
  assign bus.pc_plus4     = pc_next_seq;
  assign bus.instr_out    = instr_q;
  assign bus.instr_valid  = instr_valid_q;
  assign bus.halted       = (state_q == ST_HALT) || (state_q == ST_ERROR);
  assign bus.misalign_err = misalign_q;

endmodule
